// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive framing controller.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_e;

  localparam logic [7:0]  SOF_BYTE_DEF  = 8'h7E;
  localparam int unsigned MAX_LEN_LIMIT = 15;  // frame_len is 4 bits wide
  localparam int unsigned CNT_W         = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte cycle counter. Clear has priority over load, load over count.
// expire_o fires combinationally on the cycle the count would reach
// TIMEOUT_CYCLES, so the owner can act on the same edge.
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          inc_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          expire_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = inc_i && !clear_i && !load_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next count: clear, load, or advance while counting is requested.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                  cnt_d = '0;
    else if (load_i)              cnt_d = load_val_i;
    else if (inc_i && !expire_o)  cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream (SOF, LEN, payload, XOR checksum) into
// payloads on a valid/ready port, with error pulses and statistics.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 8,   // 1..MAX_LEN_LIMIT
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  SOF_BYTE       = SOF_BYTE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic                   uart_rx_en,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_break,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [3:0]             frame_len,
  output logic [MAX_LEN*8-1:0]   frame_data,
  output logic                   err_len,
  output logic                   err_csum,
  output logic                   err_timeout,
  output logic                   err_break,
  output logic                   err_overflow,
  output logic [CNT_W-1:0]       frame_count,
  output logic [CNT_W-1:0]       err_count
);

  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                    state_q;
  logic                      en_q;
  logic [3:0]                len_q, idx_q;
  logic [7:0]                acc_q;
  logic [MAX_LEN-1:0][7:0]   buf_q;
  logic                      fv_q;
  logic [3:0]                flen_q;
  logic [MAX_LEN*8-1:0]      fdata_q;
  logic                      e_len_q, e_csum_q, e_tmo_q, e_brk_q, e_ovf_q;
  logic [CNT_W-1:0]          fcnt_q, ecnt_q;

  logic byte_v, brk_v, in_frame, len_bad;
  logic ev_len, ev_csum, ev_tmo, ev_brk, ev_ovf, deliver, load;

  // Break-flagged strobes are never data; a disabled controller sees nothing.
  assign byte_v   = en && rx_valid && !rx_break;
  assign brk_v    = en && rx_valid && rx_break;
  assign in_frame = (state_q != ST_HUNT);
  assign len_bad  = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));

  assign ev_brk  = brk_v && in_frame;
  assign ev_len  = byte_v && (state_q == ST_LEN) && len_bad;
  assign ev_csum = byte_v && (state_q == ST_CSUM) && (rx_data != acc_q);
  assign deliver = byte_v && (state_q == ST_CSUM) && (rx_data == acc_q);
  // Output still held and not being taken this cycle: the new frame is lost.
  assign ev_ovf  = deliver && fv_q && !frame_ready;
  assign load    = deliver && !ev_ovf;

  // Any strobe (data or break) restarts the inter-byte window.
  uart_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CW(TCW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (!en || !in_frame || rx_valid),
    .inc_i      (en && in_frame && !rx_valid),
    .load_i     (1'b0),
    .load_val_i ({TCW{1'b0}}),
    .expire_o   (ev_tmo)
  );

  // Frame FSM: hunts SOF, validates LEN, collects payload, checks CSUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HUNT;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      buf_q   <= '0;
    end else if (!en || ev_brk || ev_tmo) begin
      state_q <= ST_HUNT;
    end else if (byte_v) begin
      case (state_q)
        ST_HUNT: if (rx_data == SOF_BYTE) state_q <= ST_LEN;
        ST_LEN: begin
          if (len_bad) begin
            state_q <= ST_HUNT;
          end else begin
            len_q   <= rx_data[3:0];
            acc_q   <= rx_data;   // checksum covers LEN itself
            idx_q   <= '0;
            buf_q   <= '0;        // unused bytes read back as zero
            state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          for (int i = 0; i < MAX_LEN; i++)
            if (idx_q == 4'(i)) buf_q[i] <= rx_data;
          acc_q <= acc_q ^ rx_data;
          idx_q <= idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) state_q <= ST_CSUM;
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  // Output holding register and valid/ready handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv_q    <= 1'b0;
      flen_q  <= '0;
      fdata_q <= '0;
    end else if (load) begin
      fv_q    <= 1'b1;
      flen_q  <= len_q;
      fdata_q <= buf_q;
    end else if (fv_q && frame_ready) begin
      fv_q    <= 1'b0;
    end
  end

  // Error pulses, enable mirror and saturating statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      e_len_q  <= 1'b0;
      e_csum_q <= 1'b0;
      e_tmo_q  <= 1'b0;
      e_brk_q  <= 1'b0;
      e_ovf_q  <= 1'b0;
      fcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      en_q     <= en;
      e_len_q  <= ev_len;
      e_csum_q <= ev_csum;
      e_tmo_q  <= ev_tmo;
      e_brk_q  <= ev_brk;
      e_ovf_q  <= ev_ovf;
      if (load) fcnt_q <= sat_inc(fcnt_q);
      if (ev_len || ev_csum || ev_tmo || ev_brk || ev_ovf) ecnt_q <= sat_inc(ecnt_q);
    end
  end

  assign uart_rx_en   = en_q;
  assign frame_valid  = fv_q;
  assign frame_len    = flen_q;
  assign frame_data   = fdata_q;
  assign err_len      = e_len_q;
  assign err_csum     = e_csum_q;
  assign err_timeout  = e_tmo_q;
  assign err_break    = e_brk_q;
  assign err_overflow = e_ovf_q;
  assign frame_count  = fcnt_q;
  assign err_count    = ecnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed plus randomized bench for uart_rx_frame_ctrl with a stream-level
// reference parser.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned TMO     = 100;
  localparam int unsigned DW      = MAX_LEN * 8;
  localparam logic [7:0]  SOF     = 8'h7E;

  logic            clk = 1'b0;
  logic            reset, en, rx_valid, rx_break, frame_ready;
  logic [7:0]      rx_data;
  logic            uart_rx_en, frame_valid;
  logic [3:0]      frame_len;
  logic [DW-1:0]   frame_data;
  logic            err_len, err_csum, err_timeout, err_break, err_overflow;
  logic [15:0]     frame_count, err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_fc = 0;
  int exp_ec = 0;

  uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .SOF_BYTE(SOF)) dut (
    .clk(clk), .reset(reset), .en(en), .uart_rx_en(uart_rx_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_data(frame_data),
    .err_len(err_len), .err_csum(err_csum), .err_timeout(err_timeout),
    .err_break(err_break), .err_overflow(err_overflow),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic brk = 1'b0);
    rx_valid = 1'b1; rx_data = b; rx_break = brk;
    step();
    rx_valid = 1'b0; rx_break = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] s[$], input bit gaps);
    foreach (s[k]) begin
      if (gaps && k > 0) repeat ($urandom_range(0, 2)) step();
      send(s[k]);
    end
  endtask

  // Reference: parse a complete byte stream. kind 0 none, 1 good, 2 bad length, 3 bad checksum.
  function automatic void ref_parse(input logic [7:0] s[$], output int kind,
                                    output logic [3:0] len, output logic [DW-1:0] data);
    int i = 0;
    int n;
    logic [7:0] acc;
    kind = 0; len = '0; data = '0;
    while (i < s.size() && s[i] != SOF) i++;
    if (i + 1 >= s.size()) return;
    n = int'(s[i+1]);
    if (n == 0 || n > MAX_LEN) begin kind = 2; return; end
    len = 4'(n);
    acc = s[i+1];
    for (int k = 0; k < n; k++) begin
      data[k*8 +: 8] = s[i+2+k];
      acc = acc ^ s[i+2+k];
    end
    kind = (s[i+2+n] == acc) ? 1 : 3;
  endfunction

  // Build a good frame with its checksum from a payload list.
  function automatic void mk_frame(input logic [7:0] p[$], output logic [7:0] s[$]);
    logic [7:0] c;
    c = 8'(p.size());
    s = {SOF, 8'(p.size())};
    foreach (p[k]) begin s.push_back(p[k]); c = c ^ p[k]; end
    s.push_back(c);
  endfunction

  // Check outputs right after the final byte of a stream, with frame_ready high.
  task automatic check_stream(input string tag, input logic [7:0] s[$]);
    int kind;
    logic [3:0] l;
    logic [DW-1:0] d;
    ref_parse(s, kind, l, d);
    if (kind == 1) exp_fc++;
    else if (kind >= 2) exp_ec++;
    chk({tag, ".valid"}, frame_valid, kind == 1);
    if (kind == 1) begin
      chk({tag, ".len"}, frame_len, l);
      chk({tag, ".data"}, frame_data, d);
    end
    chk({tag, ".err_len"}, err_len, kind == 2);
    chk({tag, ".err_csum"}, err_csum, kind == 3);
    chk({tag, ".fcnt"}, frame_count, exp_fc);
    chk({tag, ".ecnt"}, err_count, exp_ec);
    step();
    chk({tag, ".drop"}, frame_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] p[$];
    logic [7:0] a[$];
    reset = 1'b1; en = 1'b0; rx_valid = 1'b0; rx_break = 1'b0; rx_data = '0; frame_ready = 1'b1;
    #1;
    repeat (3) step();
    chk("rst.valid", frame_valid, 1'b0);
    chk("rst.rxen", uart_rx_en, 1'b0);
    chk("rst.data", frame_data, '0);
    chk("rst.fcnt", frame_count, '0);
    chk("rst.ecnt", err_count, '0);
    reset = 1'b0; en = 1'b1;
    step();
    chk("en.rxen", uart_rx_en, 1'b1);

    // Basic good frame and checksum error.
    s = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_q(s, 0); check_stream("good3", s);
    s = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_q(s, 0); check_stream("csum", s);

    // Length boundaries, then recovery.
    s = {8'h7E, 8'h00}; send_q(s, 0); check_stream("len0", s);
    s = {8'h7E, 8'h09}; send_q(s, 0); check_stream("len9", s);
    p = {8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    mk_frame(p, s); send_q(s, 0); check_stream("len8", s);

    // Timeout: expiry on the 100th idle cycle, and a byte on that cycle wins.
    send_q({8'h7E, 8'h02, 8'h11}, 0);
    repeat (TMO - 1) step();
    chk("tmo.early", err_timeout, 1'b0);
    step();
    exp_ec++;
    chk("tmo.pulse", err_timeout, 1'b1);
    chk("tmo.ecnt", err_count, exp_ec);
    step();
    send_q({8'h7E, 8'h02, 8'h11}, 0);
    repeat (TMO - 1) step();
    send(8'h22);
    chk("tmo.win", err_timeout, 1'b0);
    send(8'h31);
    check_stream("tmo.frame", {8'h7E, 8'h02, 8'h11, 8'h22, 8'h31});

    // Overflow while held, release, and delivery coinciding with acceptance.
    frame_ready = 1'b0;
    mk_frame({8'hAA, 8'hBB}, a); send_q(a, 0); exp_fc++;
    chk("ovf.a.valid", frame_valid, 1'b1);
    mk_frame({8'hCC}, s); send_q(s, 0); exp_ec++;
    chk("ovf.pulse", err_overflow, 1'b1);
    chk("ovf.hold", frame_data, 64'hBBAA);
    chk("ovf.hlen", frame_len, 4'd2);
    chk("ovf.ecnt", err_count, exp_ec);
    frame_ready = 1'b1;
    chk("ovf.still", frame_valid, 1'b1);
    step();
    chk("ovf.fall", frame_valid, 1'b0);
    frame_ready = 1'b0;
    send_q(a, 0); exp_fc++;
    mk_frame({8'hDE, 8'hAD, 8'h01}, s);
    for (int k = 0; k < s.size(); k++) begin
      if (k == s.size() - 1) frame_ready = 1'b1;
      send(s[k]);
    end
    exp_fc++;
    chk("coin.valid", frame_valid, 1'b1);
    chk("coin.data", frame_data, 64'h01ADDE);
    chk("coin.ovf", err_overflow, 1'b0);
    chk("coin.fcnt", frame_count, exp_fc);
    step();
    chk("coin.fall", frame_valid, 1'b0);

    // Break inside a frame, then break while hunting.
    send_q({8'h7E, 8'h03, 8'h11}, 0);
    send(8'h00, 1'b1); exp_ec++;
    chk("brk.pulse", err_break, 1'b1);
    send(8'h00, 1'b1);
    chk("brk.hunt", err_break, 1'b0);
    chk("brk.ecnt", err_count, exp_ec);
    mk_frame({8'h5A}, s); send_q(s, 0); check_stream("brk.after", s);

    // Enable drop mid-frame keeps a pending output.
    frame_ready = 1'b0;
    mk_frame({8'h42}, s); send_q(s, 0); exp_fc++;
    send_q({8'h7E, 8'h03, 8'h11}, 0);
    en = 1'b0;
    step();
    chk("en.off", uart_rx_en, 1'b0);
    chk("en.keep", frame_valid, 1'b1);
    chk("en.ecnt", err_count, exp_ec);
    en = 1'b1; frame_ready = 1'b1;
    step(); step();
    send_q({8'h22, 8'h33}, 0);
    mk_frame({8'h99, 8'h88}, s); send_q(s, 0); check_stream("en.after", s);

    // Randomized frames with garbage and inter-byte gaps.
    for (int f = 0; f < 40; f++) begin
      int r;
      int n;
      s = {};
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == SOF) g = 8'h00;
        s.push_back(g);
      end
      r = $urandom_range(0, 9);
      n = $urandom_range(1, MAX_LEN);
      p = {};
      for (int k = 0; k < n; k++) p.push_back(8'($urandom_range(0, 255)));
      mk_frame(p, a);
      if (r == 0) begin
        a = {SOF, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255))};
      end else if (r <= 2) begin
        a[a.size()-1] = a[a.size()-1] ^ 8'($urandom_range(1, 255));
      end
      s = {s, a};
      send_q(s, 1);
      check_stream($sformatf("rnd%0d", f), s);
    end

    // Reset mid-frame discards the partial frame and restarts counters.
    send_q({8'h7E, 8'h04, 8'h10}, 0);
    reset = 1'b1;
    #1;
    chk("mrst.fcnt", frame_count, '0);
    chk("mrst.ecnt", err_count, '0);
    step();
    reset = 1'b0; exp_fc = 0; exp_ec = 0;
    step();
    send_q({8'h20, 8'h30}, 0);
    mk_frame({8'h01, 8'h02}, s); send_q(s, 0); check_stream("mrst.after", s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
